// File: rtl/skolem_bvult_bvadd_checker_if.sv
// Request/acknowledge link between the Skolem checker (master) and the Skolem
// function under test (slave).
interface skolem_bvult_bvadd_checker_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] s_o;
    logic [WIDTH-1:0] t_o;
    logic             req_o;
    logic [WIDTH-1:0] x_i;
    logic             ack_i;

    modport master (output s_o, output t_o, output req_o, input x_i, input ack_i);
    modport slave  (input s_o, input t_o, input req_o, output x_i, output ack_i);
endinterface

// File: rtl/skolem_bvult_bvadd_checker.sv
// Exhaustive sweep checker for a Skolem function of (x + s) <u t.
// Optional per-vector ack watchdog: define SKOLEM_CHK_TIMEOUT_EN.
module skolem_bvult_bvadd_checker #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    skolem_bvult_bvadd_checker_if.master bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [2*WIDTH:0]       fail_cnt_o,
    output logic [2*WIDTH:0]       chk_cnt_o,
    output logic [3*WIDTH-1:0]     first_fail_o,
    output logic                   timeout_o
);
    localparam int IDX_W = 2 * WIDTH;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] x_q;
    logic             req;
    logic             start_ok;
    logic             last;
    logic             violation;
    logic             timeout_hit;
    logic             vec_end;
    logic             vec_fail;

    // Carry out of the add is discarded: the constraint lives in modulo-2^WIDTH arithmetic.
    function automatic logic bvadd_ult_fails(input logic [WIDTH-1:0] x_v,
                                             input logic [WIDTH-1:0] s_v,
                                             input logic [WIDTH-1:0] t_v);
        logic [WIDTH-1:0] sum;
        sum = x_v + s_v;
        return !(sum < t_v);
    endfunction

    assign s         = idx[WIDTH-1:0];
    assign t         = idx[IDX_W-1:WIDTH];
    assign bus.s_o   = s;
    assign bus.t_o   = t;
    assign bus.req_o = req;
    assign start_ok  = start_i && ((state == IDLE) || (state == DONE));
    assign last      = &idx;
    assign violation = (t != '0) && bvadd_ult_fails(x_q, s, t);
    assign vec_end   = (state == CHECK) || timeout_hit;
    assign vec_fail  = ((state == CHECK) && violation) || timeout_hit;
    assign pass_o    = done_o && (fail_cnt_o == '0);

`ifdef SKOLEM_CHK_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign timeout_hit = (state == DRIVE) && !bus.ack_i && (wait_cnt == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state != DRIVE) || bus.ack_i || timeout_hit) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = DRIVE;
            end
            DRIVE: begin
                req    = 1'b1;
                busy_o = 1'b1;
                if (bus.ack_i)        state_nxt = CHECK;
                else if (timeout_hit) state_nxt = last ? DONE : DRIVE;
            end
            CHECK: begin
                busy_o    = 1'b1;
                state_nxt = last ? DONE : DRIVE;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_ok) state_nxt = DRIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            x_q          <= '0;
            fail_cnt_o   <= '0;
            chk_cnt_o    <= '0;
            first_fail_o <= '0;
            timeout_o    <= 1'b0;
        end else begin
            if (start_ok) begin
                idx          <= '0;
                fail_cnt_o   <= '0;
                chk_cnt_o    <= '0;
                first_fail_o <= '0;
                timeout_o    <= 1'b0;
            end
            if ((state == DRIVE) && bus.ack_i) x_q <= bus.x_i;
            if (vec_end) begin
                if (t != '0) chk_cnt_o <= chk_cnt_o + 1'b1;
                if (!last) idx <= idx + 1'b1;
            end
            // A timed-out vector is recorded with x=0 since no answer ever arrived.
            if (vec_fail) begin
                fail_cnt_o <= fail_cnt_o + 1'b1;
                if (fail_cnt_o == '0) first_fail_o <= timeout_hit ? {t, s, {WIDTH{1'b0}}} : {t, s, x_q};
            end
            if (timeout_hit) timeout_o <= 1'b1;
        end
    end
endmodule
